router_pkt_tx: RTL and testbench

Packet transmitter for the 1-to-3 byte router: the source-side end of the router input port. It accepts a command of destination address and payload length, buffers the full payload, then drives the router's `data`/`pkt_valid` inputs. Output is a header byte, the payload bytes and a parity byte, throttled by the router's `busy`. It then watches the router's `err` to report per-packet parity status. It replaces the behavioural driver in router-level environments and serves as synthesizable traffic generation.

---
 rtl/router_pkt_tx.sv | 149 ++++++++++++++
 tb/tb_router_pkt_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one command plus payload, then drives header/payload/parity into the router and reports its parity-error status
// Ports: clk/rst (async active-low); cmd_valid/cmd_ready/cmd_addr/cmd_len/cmd_bad_par command handshake;
//        pl_valid/pl_ready/pl_data payload handshake; data/pkt_valid/busy/err router input port;
//        done/tx_err per-packet completion and error status; bad_cmd rejected-command pulse
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int CHK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_bad_par,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    output logic [7:0] data,
    output logic       pkt_valid,
    input  logic       busy,
    input  logic       err,
    output logic       done,
    output logic       tx_err,
    output logic       bad_cmd
);
    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, CHK, FIN} state_t;
    localparam int CW = $clog2(CHK_CYCLES) + 1;

    state_t        state_q, state_d;
    logic [1:0]    addr_q, addr_d;
    logic [5:0]    len_q, len_d, idx_q, idx_d;
    logic [7:0]    par_q, par_d, data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bad_par_q, bad_par_d, flag_q, flag_d;
    logic          pkt_valid_q, pkt_valid_d, cmd_ready_q, cmd_ready_d;
    logic          pl_ready_q, pl_ready_d, bad_cmd_q, bad_cmd_d;
    logic [7:0]    mem_q [MAX_LEN];
    logic          wr_en, cmd_acc, pl_acc, last, consume;

    assign cmd_acc = cmd_valid && cmd_ready_q;
    assign pl_acc  = pl_valid && pl_ready_q;
    assign last    = idx_q == len_q - 6'd1;
    assign consume = !busy;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        bad_par_d = bad_par_q;
        idx_d     = idx_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        bad_cmd_d = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: if (cmd_acc) begin
                if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                    bad_cmd_d = 1'b1;
                end else begin
                    state_d   = LOAD;
                    addr_d    = cmd_addr;
                    len_d     = cmd_len;
                    bad_par_d = cmd_bad_par;
                    idx_d     = 6'd0;
                    // parity is seeded with the header and folded in as bytes load
                    par_d     = {cmd_len, cmd_addr};
                end
            end
            LOAD: if (pl_acc) begin
                wr_en   = 1'b1;
                par_d   = par_q ^ pl_data;
                idx_d   = last ? 6'd0 : idx_q + 6'd1;
                state_d = last ? HDR : LOAD;
            end
            HDR: if (consume) state_d = PAY;
            PAY: if (consume) begin
                idx_d   = last ? idx_q : idx_q + 6'd1;
                state_d = last ? PAR : PAY;
            end
            PAR: if (consume) begin
                state_d = CHK;
                cnt_d   = '0;
            end
            CHK: begin
                flag_d  = flag_q | err;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(CHK_CYCLES - 1)) ? FIN : CHK;
            end
            FIN: begin
                flag_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered, so they are derived from the next state
        cmd_ready_d = state_d == IDLE;
        pl_ready_d  = state_d == LOAD;
        pkt_valid_d = state_d == HDR || state_d == PAY;
        data_d      = state_d == HDR ? {len_q, addr_q} :
                      state_d == PAY ? mem_q[idx_d] :
                      state_d == PAR ? par_q ^ {8{bad_par_q}} : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            bad_par_q   <= 1'b0;
            idx_q       <= '0;
            par_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            bad_par_q   <= bad_par_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            cmd_ready_q <= cmd_ready_d;
            pl_ready_q  <= pl_ready_d;
            bad_cmd_q   <= bad_cmd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q] <= pl_data;
    end

    assign cmd_ready = cmd_ready_q;
    assign pl_ready  = pl_ready_q;
    assign data      = data_q;
    assign pkt_valid = pkt_valid_q;
    assign bad_cmd   = bad_cmd_q;
    assign done      = state_q == FIN;
    assign tx_err    = state_q == FIN && flag_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: table-driven packets checked against a byte/status scoreboard, plus reset sequences
module tb_router_pkt_tx;
    localparam int CHK = 4;

    logic       clk = 1'b0, rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_bad_par = 1'b0, pl_valid = 1'b0, busy = 1'b0, err = 1'b0;
    logic [1:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic [7:0] pl_data = '0;
    logic       cmd_ready, pl_ready, pkt_valid, done, tx_err, bad_cmd;
    logic [7:0] data;

    router_pkt_tx #(.MAX_LEN(63), .CHK_CYCLES(CHK)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_bad_par(cmd_bad_par),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .data(data), .pkt_valid(pkt_valid), .busy(busy), .err(err),
        .done(done), .tx_err(tx_err), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        bit         par;
        bit         inj;
        bit         txe;
    } item_t;
    typedef struct {
        int c;
        bit txe;
    } done_t;
    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        bit         bp;
        int         pat;
        bit         gaps;
        bit         stall;
        bit         inj;
        bit         rej;
        bit         txe;
        bit         chk_par;
        logic [7:0] par;
    } vec_t;

    int         checks = 0, failures = 0, cyc = 0, first_pv = -1;
    item_t      exp_q[$];
    done_t      done_q[$];
    int         bad_q[$];
    item_t      mon_h;
    done_t      mon_d;
    bit         armed = 1'b0, stall_armed = 1'b0;
    logic [7:0] last_par = '0, stall_val = '0;
    logic [7:0] pay [64];
    vec_t       vt [8];
    event       err_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: pop on consume at the rising edge, compare at the falling edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (armed && !busy && exp_q.size() > 0) begin
            mon_h = exp_q.pop_front();
            if (mon_h.par) begin
                armed = 1'b0;
                mon_d.c   = cyc + CHK;
                mon_d.txe = mon_h.txe;
                done_q.push_back(mon_d);
                if (mon_h.inj) -> err_ev;
            end
        end
        @(negedge clk);
        if (!armed && pkt_valid && exp_q.size() > 0) begin
            armed    = 1'b1;
            first_pv = cyc;
        end
        if (armed) begin
            chk("data", data, exp_q[0].d);
            chk("pkt_valid", pkt_valid, exp_q[0].v);
            if (exp_q[0].par) last_par = data;
        end else if (pkt_valid) begin
            chk("stray_pkt_valid", pkt_valid, 0);
        end
        if (done_q.size() > 0 && done_q[0].c == cyc) begin
            chk("done", done, 1);
            chk("tx_err", tx_err, done_q[0].txe);
            done_q.delete(0);
        end else if (done) begin
            chk("stray_done", done, 0);
        end
        if (bad_q.size() > 0 && bad_q[0] == cyc) begin
            chk("bad_cmd", bad_cmd, 1);
            bad_q.delete(0);
        end else if (bad_cmd) begin
            chk("stray_bad_cmd", bad_cmd, 0);
        end
    end

    // router error model: err on the last cycle of the check window
    initial forever begin
        @(err_ev);
        repeat (3) @(posedge clk);
        #1 err = 1'b1;
        @(posedge clk);
        #1 err = 1'b0;
    end

    // backpressure: busy high for two edges starting when stall_val first appears
    initial forever begin
        @(negedge clk);
        if (stall_armed && pkt_valid && data == stall_val) begin
            stall_armed = 1'b0;
            busy = 1'b1;
            repeat (2) @(negedge clk);
            busy = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_pkt(input logic [1:0] a, input logic [5:0] l, input bit bp, input bit inj, input bit txe);
        item_t      it;
        logic [7:0] p;
        p  = {l, a};
        it = '{p, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(it);
        for (int i = 0; i < int'(l); i++) begin
            it.d = pay[i];
            exp_q.push_back(it);
            p ^= pay[i];
        end
        it = '{bp ? ~p : p, 1'b0, 1'b1, inj, txe};
        exp_q.push_back(it);
        first_pv = -1;
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input bit bp, output int acc);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_bad_par = bp;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (acc < 0) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic load(input int n, input bit gaps, output int last);
        last = -1;
        for (int i = 0; i < n; i++) begin
            bit ok;
            ok = 1'b0;
            if (gaps) begin
                pl_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            pl_valid = 1'b1;
            pl_data  = pay[i];
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (pl_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1 last = cyc;
            if (!ok) begin
                chk("pl_accept_timeout", 0, 1);
                break;
            end
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_q.size() == 0 && bad_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("drain_timeout", 0, 1);
            exp_q.delete(); done_q.delete(); bad_q.delete();
            armed = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int acc, last;
        for (int i = 0; i < 64; i++)
            pay[i] = v.pat == 0 ? 8'((i + 1) * 17) : v.pat == 1 ? 8'hFF : 8'($urandom);
        stall_val   = pay[1];
        stall_armed = v.stall;
        if (v.rej) begin
            send_cmd(v.addr, v.len, v.bp, acc);
            bad_q.push_back(acc);
            repeat (3) begin
                @(negedge clk);
                chk("rej_cmd_ready", cmd_ready, 1);
                chk("rej_pl_ready", pl_ready, 0);
            end
            wait_idle();
        end else begin
            push_pkt(v.addr, v.len, v.bp, v.inj, v.txe);
            send_cmd(v.addr, v.len, v.bp, acc);
            load(int'(v.len), v.gaps, last);
            if (!v.gaps) chk("load_latency", last, acc + int'(v.len));
            wait_idle();
            chk("hdr_timing", first_pv, last);
            if (v.chk_par) chk("parity_byte", last_par, v.par);
        end
        stall_armed = 1'b0;
    endtask

    initial begin
        int acc, last;
        bit hit;
        vt[0] = '{2'd1, 6'd3,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D};
        vt[1] = '{2'd1, 6'd3,  1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D};
        vt[2] = '{2'd1, 6'd3,  1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF2};
        vt[3] = '{2'd3, 6'd5,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[4] = '{2'd0, 6'd0,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[5] = '{2'd0, 6'd63, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
        vt[6] = '{2'd2, 6'd7,  1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[7] = '{2'd2, 6'd1,  1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_err", tx_err, 0);
        chk("rst_bad_cmd", bad_cmd, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("cmd_ready_after_edge", cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // reset while the 10th payload byte is being offered
        for (int i = 0; i < 64; i++) pay[i] = 8'(i + 1);
        send_cmd(2'd1, 6'd20, 1'b0, acc);
        load(9, 1'b0, last);
        pl_valid = 1'b1;
        pl_data  = pay[9];
        #2 rst = 1'b0;
        #1;
        chk("rst_load_pl_ready", pl_ready, 0);
        chk("rst_load_cmd_ready", cmd_ready, 0);
        chk("rst_load_pkt_valid", pkt_valid, 0);
        chk("rst_load_data", data, 0);
        pl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset while the 10th payload byte is on the router bus
        push_pkt(2'd1, 6'd20, 1'b0, 1'b0, 1'b0);
        send_cmd(2'd1, 6'd20, 1'b0, acc);
        load(20, 1'b0, last);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pkt_valid && data == 8'h0A) begin
                hit = 1'b1;
                break;
            end
        end
        chk("tenth_byte_seen", hit, 1);
        #2 rst = 1'b0;
        exp_q.delete(); done_q.delete();
        armed = 1'b0;
        #1;
        chk("rst_tx_data", data, 0);
        chk("rst_tx_pkt_valid", pkt_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) @(negedge clk);

        run_vec(vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
